// File: rtl/wave_capture.sv
// Purpose : double-buffered 256-sample oscilloscope capture with level trigger / auto-trigger.
// Latency : rd_data is registered, 1 cycle after rd_addr; capture takes 1 + 255*stride cycles.
// Backpressure: none on i_wave; a finished capture waits in DONE until frame_start swaps banks.
//
// Ports:
//   clk, rst_n      sample clock, asynchronous active-low reset
//   i_wave          8-bit unsigned sample, one per clk
//   i_decim         stride select 0..3 -> 1,2,4,8 clk per stored sample (sampled while waiting)
//   frame_start     vertical-blanking pulse; swaps banks only when a capture is complete
//   rd_addr/rd_data display-bank read port (1-cycle latency)
//   o_ready         a complete capture is waiting for a swap
//   o_auto          displayed capture was started by timeout rather than a level crossing
//   o_bank          index of the bank currently displayed
module wave_capture #(
    parameter logic [7:0]  TRIG_LEVEL = 8'd128,
    parameter int unsigned TIMEOUT    = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_wave,
    input  logic [1:0] i_decim,
    input  logic       frame_start,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       o_ready,
    output logic       o_auto,
    output logic       o_bank
);

    typedef enum logic [1:0] {
        WAIT_TRIG = 2'd0,
        CAPTURE   = 2'd1,
        DONE      = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  prev_q;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  stride_q, stride_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [7:0]  widx_q, widx_d;
    logic        auto_lat_q, auto_lat_d;
    logic        bank_q, bank_d;
    logic        auto_q, auto_d;
    logic [7:0]  rd_data_q;
    logic        wr_en;
    logic        crossing;

    // Both banks in one array; the write side always targets ~bank_q, the
    // read side bank_q, so the two ports never touch the same bank.
    logic [7:0]  mem [0:1][0:255];

    // prev_q resets to 8'hFF so the first cycle after reset can never look like a crossing.
    assign crossing = (prev_q < TRIG_LEVEL) && (i_wave >= TRIG_LEVEL);

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        stride_d   = stride_q;
        scnt_d     = scnt_q;
        widx_d     = widx_q;
        auto_lat_d = auto_lat_q;
        bank_d     = bank_q;
        auto_d     = auto_q;
        wr_en      = 1'b0;

        case (state_q)
            WAIT_TRIG: begin
                // Stride follows i_decim while waiting and freezes once capture begins.
                stride_d = 4'd1 << i_decim;
                tmo_d    = tmo_q + 16'd1;
                if (crossing || (tmo_q == TO_LAST)) begin
                    // widx_q is 0 here, so the trigger sample lands at index 0.
                    wr_en      = 1'b1;
                    widx_d     = 8'd1;
                    scnt_d     = 4'd0;
                    tmo_d      = 16'd0;
                    auto_lat_d = ~crossing;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (scnt_q == (stride_q - 4'd1)) begin
                    wr_en  = 1'b1;
                    scnt_d = 4'd0;
                    widx_d = widx_q + 8'd1;   // wraps to 0 after index 255
                    if (widx_q == 8'd255) begin
                        state_d = DONE;
                    end
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
            end
            DONE: begin
                if (frame_start) begin
                    bank_d  = ~bank_q;
                    auto_d  = auto_lat_q;
                    tmo_d   = 16'd0;
                    state_d = WAIT_TRIG;
                end
            end
            default: begin
                state_d = WAIT_TRIG;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_TRIG;
            prev_q     <= 8'hFF;
            tmo_q      <= 16'd0;
            stride_q   <= 4'd1;
            scnt_q     <= 4'd0;
            widx_q     <= 8'd0;
            auto_lat_q <= 1'b0;
            bank_q     <= 1'b0;
            auto_q     <= 1'b0;
            rd_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= i_wave;
            tmo_q      <= tmo_d;
            stride_q   <= stride_d;
            scnt_q     <= scnt_d;
            widx_q     <= widx_d;
            auto_lat_q <= auto_lat_d;
            bank_q     <= bank_d;
            auto_q     <= auto_d;
            rd_data_q  <= mem[bank_q][rd_addr];
        end
    end

    // Sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[~bank_q][widx_q] <= i_wave;
        end
    end

    assign rd_data = rd_data_q;
    assign o_ready = (state_q == DONE);
    assign o_auto  = auto_q;
    assign o_bank  = bank_q;

endmodule

// File: tb/tb_wave_capture.sv
// Purpose : randomized scoreboard bench for wave_capture against a trigger/capture reference model.
// Latency : reads are checked one cycle after issue by an independent monitor.
// Backpressure: none; frame_start is driven by the bench to accept each capture.
module tb_wave_capture;

    localparam int TO   = 100;
    localparam int NMAX = 2200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_wave;
    logic [1:0] i_decim;
    logic       frame_start;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       o_ready;
    logic       o_auto;
    logic       o_bank;

    always #5 clk = ~clk;

    wave_capture #(.TRIG_LEVEL(8'd128), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wave      (i_wave),
        .i_decim     (i_decim),
        .frame_start (frame_start),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .o_ready     (o_ready),
        .o_auto      (o_auto),
        .o_bank      (o_bank)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       rd_req   = 1'b0;
    logic       rd_req_d = 1'b0;
    logic [7:0] disp [256];
    logic [7:0] cap  [256];
    logic [7:0] wv   [NMAX];
    logic [1:0] dv   [NMAX];
    logic       exp_bank;
    logic       exp_auto;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Read-side monitor: every read issued before a posedge is answered at the next negedge.
    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (rd_req_d) begin
            if (exp_q.size() == 0) begin
                check("rd_queue_underflow", 1, 0);
            end else begin
                check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    // Issues n reads of the displayed bank; expectations are pushed at issue time.
    task automatic read_disp(input int n);
        logic [7:0] snap [256];
        int a;
        snap = disp;
        for (int j = 0; j < n; j++) begin
            a = (j == 0) ? 0 : (j == 1) ? 255 : int'($urandom_range(0, 255));
            @(negedge clk);
            rd_addr = 8'(a);
            rd_req  = 1'b1;
            exp_q.push_back(snap[a]);
        end
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    // One full trigger/capture/swap. The DUT must be in WAIT_TRIG with prev = 255
    // and the caller positioned just after a posedge.
    // mode: 0 ramp from base, 1 constant base, 2 random full range, 3 random below 128
    // dmode: 0..3 fixed decim, 4 random every cycle
    task automatic run_capture(input int mode, input int base, input int dmode,
                               input bit fs_last, input int abort_after);
        int t, s, done, got, p;
        bit auto_f;
        for (int i = 0; i < NMAX; i++) begin
            case (mode)
                0:       wv[i] = 8'(base + i);
                1:       wv[i] = 8'(base);
                2:       wv[i] = 8'($urandom_range(0, 255));
                default: wv[i] = 8'($urandom_range(0, 127));
            endcase
            dv[i] = (dmode < 4) ? 2'(dmode) : 2'($urandom_range(0, 3));
        end
        if (mode == 2) wv[0] = 8'd200;

        // Reference: first upward crossing of 128, else auto-trigger at cycle TO-1.
        t = -1;
        auto_f = 1'b0;
        for (int i = 0; i < TO && t < 0; i++) begin
            p = (i == 0) ? 255 : int'(wv[i-1]);
            if (p < 128 && int'(wv[i]) >= 128) begin
                t = i; auto_f = 1'b0;
            end else if (i == TO - 1) begin
                t = i; auto_f = 1'b1;
            end
        end
        s = 1 << dv[t];
        for (int k = 0; k < 256; k++) cap[k] = wv[t + k * s];
        done = t + 255 * s;

        got = -1;
        for (int i = 0; i < NMAX; i++) begin
            @(negedge clk);
            i_wave      = wv[i];
            i_decim     = dv[i];
            frame_start = (fs_last && i == done) ||
                          (mode >= 2 && i < done && $urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            if (abort_after >= 0 && i == t + abort_after) return;
            if (o_ready) begin
                got = i;
                break;
            end
        end
        check("ready_cycle", got, done);
        check("bank_before_swap", int'(o_bank), int'(exp_bank));

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_wave      = 8'($urandom_range(0, 255));
            i_decim     = 2'($urandom_range(0, 3));
            frame_start = 1'b0;
            @(posedge clk);
            #1;
        end
        check("ready_hold", int'(o_ready), 1);

        @(negedge clk);
        i_wave      = 8'd255;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        exp_bank = ~exp_bank;
        exp_auto = auto_f;
        disp     = cap;
        check("bank_after_swap", int'(o_bank), int'(exp_bank));
        check("auto_after_swap", int'(o_auto), int'(exp_auto));
        check("ready_after_swap", int'(o_ready), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 5000000", $time);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        i_wave      = 8'd255;
        i_decim     = 2'd0;
        frame_start = 1'b0;
        rd_addr     = 8'd0;
        exp_bank    = 1'b0;
        exp_auto    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(o_ready), 0);
        check("rst_auto", int'(o_auto), 0);
        check("rst_bank", int'(o_bank), 0);
        check("rst_rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp, stride 1: trigger at sample 128, stored[k] = 128+k.
        run_capture(0, 60, 0, 1'b0, -1);
        // Ramp, stride 4: stored[k] = 128+4k, 1021-cycle capture.
        fork read_disp(100); run_capture(0, 100, 2, 1'b0, -1); join
        // Constant below level: auto-trigger.
        fork read_disp(100); run_capture(1, 50, 0, 1'b0, -1); join
        // Random waves, random decim every cycle, stray frame_start pulses.
        for (int it = 0; it < 3; it++) begin
            fork read_disp(100); run_capture((it % 2 == 0) ? 2 : 3, 0, 4, 1'b0, -1); join
        end
        // frame_start on the index-255 write cycle must not swap.
        fork read_disp(100); run_capture(1, 200, 1, 1'b1, -1); join

        // Abort a capture at index 100 with an asynchronous reset.
        fork read_disp(100); run_capture(0, 100, 0, 1'b0, 100); join
        rst_n = 1'b0;
        #1;
        check("midrst_ready", int'(o_ready), 0);
        check("midrst_bank", int'(o_bank), 0);
        check("midrst_auto", int'(o_auto), 0);
        check("midrst_rd_data", int'(rd_data), 0);
        exp_bank = 1'b0;
        exp_auto = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_capture(2, 0, 4, 1'b0, -1);
        @(negedge clk);
        frame_start = 1'b0;
        i_wave      = 8'd255;
        read_disp(100);
        repeat (2) @(negedge clk);
        check("rd_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
